// File: rtl/demux_pkg.sv
// Shared constants for the 4-way write-side demux; see demux4_route.sv for the
// optional DEMUX_BROADCAST_EN build.
package demux_pkg;

  localparam int NUM_WAYS = 4;
  localparam int SEL_W    = 2;

  localparam int CH_REG = 0;
  localparam int CH_MEM = 1;
  localparam int CH_PC  = 2;
  localparam int CH_DBG = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_WAYS-1:0] sel_onehot(input sel_t sel);
    sel_onehot = NUM_WAYS'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single demux channel with valid/ready
// handshake; can_load lets the word be replaced in the cycle it drains.
module demux_slot
  import demux_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [LENGTH:1] din,
  input  logic            take,
  output logic [LENGTH:1] dout,
  output logic            full,
  output logic            can_load
);

  logic [0:0]      state_q, state_d;
  logic [LENGTH:1] data_q, data_d;

  assign full     = (state_q == ST_FULL);
  assign can_load = !full | take;
  assign dout     = data_q;

  // A load wins over a drain; the data register keeps its value once emptied.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = ST_FULL;
      data_d  = din;
    end else if (full && take) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/demux4_route.sv
// Routes one source word to one of four buffered destination channels.
// Defining DEMUX_BROADCAST_EN adds the bcast port for an all-channel write.
module demux4_route
  import demux_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      s,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LENGTH:1] d,
`ifdef DEMUX_BROADCAST_EN
  input  logic            bcast,
`endif
  output logic [LENGTH:1] y0,
  output logic [LENGTH:1] y1,
  output logic [LENGTH:1] y2,
  output logic [LENGTH:1] y3,
  output logic            v0,
  output logic            v1,
  output logic            v2,
  output logic            v3,
  input  logic            r0,
  input  logic            r1,
  input  logic            r2,
  input  logic            r3
);

  logic [NUM_WAYS-1:0] take_w, load_w, full_w, can_w, sel_oh;
  logic [LENGTH:1]     dout_w [NUM_WAYS];
  logic                accept;

  assign take_w[CH_REG] = r0;
  assign take_w[CH_MEM] = r1;
  assign take_w[CH_PC]  = r2;
  assign take_w[CH_DBG] = r3;

  assign sel_oh = sel_onehot(s);
  assign accept = in_valid & in_ready;

  // Ready depends only on slot occupancy and consumer ready, never on d.
`ifdef DEMUX_BROADCAST_EN
  assign in_ready = bcast ? (&can_w) : can_w[s];
  assign load_w   = accept ? (bcast ? {NUM_WAYS{1'b1}} : sel_oh) : '0;
`else
  assign in_ready = can_w[s];
  assign load_w   = {NUM_WAYS{accept}} & sel_oh;
`endif

  for (genvar k = 0; k < NUM_WAYS; k++) begin : g_slot
    demux_slot #(.LENGTH(LENGTH)) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_w[k]),
      .din      (d),
      .take     (take_w[k]),
      .dout     (dout_w[k]),
      .full     (full_w[k]),
      .can_load (can_w[k])
    );
  end

  assign y0 = dout_w[CH_REG];
  assign y1 = dout_w[CH_MEM];
  assign y2 = dout_w[CH_PC];
  assign y3 = dout_w[CH_DBG];
  assign v0 = full_w[CH_REG];
  assign v1 = full_w[CH_MEM];
  assign v2 = full_w[CH_PC];
  assign v3 = full_w[CH_DBG];

endmodule
